// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) built from two chained
// half-subtractor stages and a borrow flip-flop. Optional signed overflow via SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_borrow_out;
    logic             r_done;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             w_last;
    logic             w_d1;
    logic             w_b1;
    logic             w_d;
    logic             w_b2;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    // Two half-subtractors: operand bits first, then the stored borrow.
    assign w_d1   = r_a_sr[0] ^ r_b_sr[0];
    assign w_b1   = ~r_a_sr[0] & r_b_sr[0];
    assign w_d    = w_d1 ^ r_borrow;
    assign w_b2   = ~w_d1 & r_borrow;
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res        <= '0;
            r_diff       <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
            r_done       <= 1'b0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf        <= 1'b0;
`endif
        end else begin
            r_done <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                S_SHIFT: begin
                    // Result enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                    r_res    <= {w_d, r_res[WIDTH-1:1]};
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_borrow <= w_b1 | w_b2;
                    r_cnt    <= r_cnt + CW'(1);
                end
                S_FIN: begin
                    r_diff       <= r_res;
                    r_borrow_out <= r_borrow;
`ifdef SERIAL_SUB_OVF_EN
                    r_ovf        <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ r_res[WIDTH-1]);
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf        = r_ovf;
`else
    // Operand MSBs only feed the overflow term; keep them observed in the default build.
    logic w_unused;
    assign w_unused = r_a_msb ^ r_b_msb;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed, randomized and
// control-scenario tests against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Runs one operation starting now (just after a rising edge); returns on the done cycle.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit hold,
                         input string name);
        int            exp_diff;
        int            sa;
        int            sb;
        logic [W-1:0]  prev_diff;
        bit            exp_borrow;
        bit            exp_ovf;
        bit            got_done;
        bit            unstable;
        int            n;
        int            busy_cnt;
        exp_diff   = (int'(ia) - int'(ib) + 256) % 256;
        exp_borrow = (ia < ib);
        sa         = ia[W-1] ? int'(ia) - 256 : int'(ia);
        sb         = ib[W-1] ? int'(ib) - 256 : int'(ib);
        exp_ovf    = ((sa - sb) > 127) || ((sa - sb) < -128);
        prev_diff  = diff;
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        n = 0; busy_cnt = 0; got_done = 0; unstable = 0;
        while (n < 30) begin
            if (busy) busy_cnt++;
            a = W'($urandom); b = W'($urandom);
            if (done) begin
                got_done = 1;
                break;
            end
            if (diff !== prev_diff) unstable = 1;
            @(posedge clk); #1;
            n++;
        end
        if (hold) start = 1'b0;
        n_checks++;
        if (!got_done) begin
            n_errors++;
            $display("FAIL %s timeout: no done after %0d cycles, required done at %0d", name, n, W + 1);
            return;
        end
        n_checks++;
        if (n !== W + 1) begin
            n_errors++;
            $display("FAIL %s latency: got %0d, required %0d", name, n, W + 1);
        end
        n_checks++;
        if (busy_cnt !== W + 1) begin
            n_errors++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cnt, W + 1);
        end
        n_checks++;
        if (unstable) begin
            n_errors++;
            $display("FAIL %s diff_hold: diff changed before done, required stable at %h", name, prev_diff);
        end
        n_checks++;
        if (diff !== W'(exp_diff)) begin
            n_errors++;
            $display("FAIL %s diff: a=%h b=%h got %h, required %h", name, ia, ib, diff, W'(exp_diff));
        end
        n_checks++;
        if (borrow_out !== exp_borrow) begin
            n_errors++;
            $display("FAIL %s borrow: a=%h b=%h got %b, required %b", name, ia, ib, borrow_out, exp_borrow);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_checks++;
        if (ovf !== exp_ovf) begin
            n_errors++;
            $display("FAIL %s ovf: a=%h b=%h got %b, required %b", name, ia, ib, ovf, exp_ovf);
        end
`else
        if (exp_ovf && 1'b0) $display("unreachable");
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, diff, borrow_out} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy, done, diff, borrow_out);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_op(8'h05, 8'h03, 0, "dir_05_03");
        do_op(8'h03, 8'h05, 0, "dir_03_05");
        do_op(8'h00, 8'h01, 0, "dir_00_01");
        do_op(8'hFF, 8'hFF, 0, "dir_FF_FF");
        do_op(8'h00, 8'h00, 0, "dir_00_00");
        do_op(8'h7F, 8'h80, 0, "dir_7F_80");
    endtask

    task automatic test_random_back_to_back();
        for (int i = 0; i < 40; i++) do_op(W'($urandom), W'($urandom), 0, "rand_b2b");
    endtask

    task automatic test_busy_ignore();
        int extra_done;
        do_op(8'h5A, 8'h21, 1, "busy_ignore");
        extra_done = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        n_checks++;
        if (extra_done !== 0) begin
            n_errors++;
            $display("FAIL busy_ignore_done_count: got %0d extra done pulses, required 0", extra_done);
        end
        n_checks++;
        if (busy !== 1'b0 || diff !== 8'h39) begin
            n_errors++;
            $display("FAIL busy_ignore_idle: got busy=%b diff=%h, required busy=0 diff=39", busy, diff);
        end
    endtask

    task automatic test_mid_reset();
        do_op(8'h03, 8'h05, 0, "pre_reset");
        a = 8'h44; b = 8'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, diff, borrow_out} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy, done, diff, borrow_out);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || diff !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_idle: got busy=%b diff=%h, required busy=0 diff=00", busy, diff);
        end
        do_op(8'h44, 8'h11, 0, "post_reset");
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        do_op(8'h80, 8'h01, 0, "ovf_80_01");
        do_op(8'h10, 8'h01, 0, "ovf_10_01");
        do_op(8'h7F, 8'hFF, 0, "ovf_7F_FF");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random_back_to_back();
        test_busy_ignore();
        test_mid_reset();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
